// File: rtl/core_pkg.sv
// Shared types for the parametrised accumulator core: opcode, format and FSM state encodings.
package core_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SHL = 3'd5,
    SHR = 3'd6,
    MOV = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    FMT_REG  = 2'd0,
    FMT_IMM  = 2'd1,
    FMT_ILL2 = 2'd2,
    FMT_ILL3 = 2'd3
  } fmt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic fmt_legal(input fmt_t f);
    return (f == FMT_REG) || (f == FMT_IMM);
  endfunction

endpackage

// File: rtl/param_core_alu.sv
// Combinational ALU: eight operations with carry/borrow and zero flags.
module param_alu
  import core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_t               op,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              z
);

  localparam int SHW = $clog2(DATA_W);

  logic [SHW-1:0] sh_amt;
  assign sh_amt = b[SHW-1:0];

  // Result and carry select; C is only meaningful for ADD/SUB.
  always_comb begin
    y = {DATA_W{1'b0}};
    c = 1'b0;
    case (op)
      ADD:     {c, y} = {1'b0, a} + {1'b0, b};
      SUB:     begin
        y = a - b;
        c = (a < b);
      end
      AND:     y = a & b;
      OR:      y = a | b;
      XOR:     y = a ^ b;
      SHL:     y = a << sh_amt;
      SHR:     y = a >> sh_amt;
      MOV:     y = b;
      default: begin
        y = {DATA_W{1'b0}};
        c = 1'b0;
      end
    endcase
  end

  assign z = (y == {DATA_W{1'b0}});

endmodule

// File: rtl/param_core.sv
// Parametrised accumulator core: valid/ready instruction intake, 3-state FSM,
// register file, Z/C flags, illegal-format pulse and a debug read port.
module param_core
  import core_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int IMM_W  = 8,
  localparam int RAW     = $clog2(NREGS),
  localparam int INSTR_W = RAW + IMM_W + 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  d_out,
  output logic               done,
  output logic               flag_z,
  output logic               flag_c,
  output logic               illegal,
  input  logic [RAW-1:0]     dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_t             state_q, state_d;
  logic               ready_q;
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [DATA_W-1:0]  res_q, d_out_q;
  logic               c_q, z_q, legal_q;
  logic               flag_z_q, flag_c_q, done_q, illegal_q;

  logic [RAW-1:0]     rx_s, ry_s;
  logic [IMM_W-1:0]   field_s;
  op_t                op_s;
  fmt_t               fmt_s;
  logic [DATA_W-1:0]  a_s, b_s, y_s;
  logic               c_s, z_s, accept_s;

  assign rx_s     = ir_q[INSTR_W-1 -: RAW];
  assign field_s  = ir_q[IMM_W+4 -: IMM_W];
  assign ry_s     = field_s[IMM_W-1 -: RAW];
  assign op_s     = op_t'(ir_q[4:2]);
  assign fmt_s    = fmt_t'(ir_q[1:0]);
  assign a_s      = regs_q[rx_s];
  assign b_s      = (fmt_s == FMT_REG) ? regs_q[ry_s] : DATA_W'(field_s);
  // ready_q stays low through reset and its first post-release edge, so no accept sneaks in there.
  assign accept_s = instr_valid && ready_q;

  param_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (a_s),
    .b  (b_s),
    .op (op_s),
    .y  (y_s),
    .c  (c_s),
    .z  (z_s)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = EXEC;
        else          state_d = IDLE;
      end
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, instruction latch, execute latches and retire pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      ir_q      <= {INSTR_W{1'b0}};
      res_q     <= {DATA_W{1'b0}};
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      legal_q   <= 1'b0;
      d_out_q   <= {DATA_W{1'b0}};
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      done_q    <= (state_q == WB);
      illegal_q <= (state_q == WB) && !legal_q;
      if ((state_q == IDLE) && accept_s) begin
        ir_q <= instr;
      end
      if (state_q == EXEC) begin
        res_q   <= y_s;
        c_q     <= c_s;
        z_q     <= z_s;
        legal_q <= fmt_legal(fmt_s);
      end
      if ((state_q == WB) && legal_q) begin
        d_out_q  <= res_q;
        flag_z_q <= z_q;
        flag_c_q <= c_q;
      end
    end
  end

  // Register file write-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= {DATA_W{1'b0}};
    end else if ((state_q == WB) && legal_q) begin
      regs_q[rx_s] <= res_q;
    end
  end

  assign instr_ready = ready_q;
  assign d_out       = d_out_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_param_core.sv
// Directed self-checking bench for param_core at default parameters.
module tb_param_core;

  logic        clk;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] d_out;
  logic        done;
  logic        flag_z;
  logic        flag_c;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int tests_run;
  int tests_failed;

  param_core dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .d_out       (d_out),
    .done        (done),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction at a negedge, then watch for done; returns latency in edges after accept.
  task automatic run_instr(input logic [15:0] w, output int lat, output int ready_low,
                           output logic ill_at_done);
    lat = -1;
    ready_low = 0;
    ill_at_done = 1'b0;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = ~w;
    for (int i = 0; i < 10; i++) begin
      if (!instr_ready) ready_low++;
      if (done) begin
        lat = i;
        ill_at_done = illegal;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic dbg(input logic [2:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  int          lat, rlow, acc, dn;
  logic        ill;
  logic [15:0] v;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    instr = 16'h0000;
    instr_valid = 1'b0;
    dbg_addr = 3'd0;

    #12;
    check("ready_in_reset", {31'd0, instr_ready}, 32'd0);
    check("dout_reset", {16'd0, d_out}, 32'h0);
    check("done_reset", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'd0, instr_ready}, 32'd1);

    // ADD r1,#5
    run_instr(16'h20A1, lat, rlow, ill);
    check("add_imm_latency", lat, 32'd2);
    check("add_imm_ready_low", rlow, 32'd2);
    check("add_imm_ready_at_done", {31'd0, instr_ready}, 32'd1);
    check("add_imm_dout", {16'd0, d_out}, 32'h0005);
    check("add_imm_flags", {30'd0, flag_z, flag_c}, 32'd0);
    check("add_imm_illegal", {31'd0, ill}, 32'd0);
    dbg(3'd1, v);
    check("add_imm_r1", {16'd0, v}, 32'h0005);

    // ADD r1,r1 (rx == ry)
    run_instr(16'h2400, lat, rlow, ill);
    check("add_rr_dout", {16'd0, d_out}, 32'h000A);
    dbg(3'd1, v);
    check("add_rr_r1", {16'd0, v}, 32'h000A);

    // Carry/zero sequence on r2
    run_instr(16'h5FFD, lat, rlow, ill);
    dbg(3'd2, v);
    check("mov_r2", {16'd0, v}, 32'h00FF);
    run_instr(16'h4115, lat, rlow, ill);
    dbg(3'd2, v);
    check("shl_r2", {16'd0, v}, 32'hFF00);
    run_instr(16'h5FE1, lat, rlow, ill);
    dbg(3'd2, v);
    check("add_ff_r2", {16'd0, v}, 32'hFFFF);
    check("add_ff_flags", {30'd0, flag_z, flag_c}, 32'd0);
    run_instr(16'h4021, lat, rlow, ill);
    check("wrap_dout", {16'd0, d_out}, 32'h0000);
    check("wrap_flags_zc", {30'd0, flag_z, flag_c}, 32'd3);

    // SUB r3,#1 from zero
    run_instr(16'h6025, lat, rlow, ill);
    dbg(3'd3, v);
    check("sub_r3", {16'd0, v}, 32'hFFFF);
    check("sub_flags_zc", {30'd0, flag_z, flag_c}, 32'd1);

    // Illegal format: pulse, no architectural change
    run_instr(16'h20A2, lat, rlow, ill);
    check("ill_latency", lat, 32'd2);
    check("ill_pulse", {31'd0, ill}, 32'd1);
    check("ill_dout", {16'd0, d_out}, 32'hFFFF);
    check("ill_flags_zc", {30'd0, flag_z, flag_c}, 32'd1);
    dbg(3'd1, v);
    check("ill_r1", {16'd0, v}, 32'h000A);
    @(negedge clk);
    check("ill_pulse_one_cycle", {30'd0, done, illegal}, 32'd0);

    // Reset one cycle after accepting ADD r1,#5
    @(negedge clk);
    instr = 16'h20A1;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_mid_dout", {16'd0, d_out}, 32'h0);
    dn = 0;
    @(negedge clk);
    if (done) dn++;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("rst_no_done", dn, 32'd0);
    dbg(3'd1, v);
    check("rst_r1", {16'd0, v}, 32'h0000);

    // Back-to-back with valid held high: one accept per 3 cycles
    instr = 16'h20A1;
    instr_valid = 1'b1;
    acc = 0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready) acc++;
      if (done) dn++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("stream_accepts", acc, 32'd4);
    check("stream_dones", dn, 32'd3);
    for (int i = 0; i < 4; i++) @(negedge clk);
    dbg(3'd1, v);
    check("stream_r1", {16'd0, v}, 32'h0014);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_core.md
Name: param_core

Overview:
- Parametrised successor to the fixed 16-bit, 8-register accumulator core.
- Width, register count and immediate width are generic.
- Adds a valid/ready instruction handshake, Z/C flags, illegal-format detection and a debug register-read port.
- Sits between the instruction source (switches, ROM or testbench) and the display/debug logic. Executes one instruction per accepted transfer as a 3-state multi-cycle FSM.

Parameters:
- DATA_W, 16, datapath and register width; must be >= IMM_W.
- NREGS, 8, number of general registers; power of two, >= 2.
- IMM_W, 8, immediate field width; must be >= RAW.
- localparam RAW = $clog2(NREGS), register address width.
- localparam INSTR_W = RAW+IMM_W+5, instruction width (16 at defaults).

Ports:
- clk  in  1  core clock; one clock, all state on rising edge.
- reset_n  in  1  reset is asynchronous and active-low.
- instr  in  INSTR_W  instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  core can accept an instruction (IDLE).
- d_out  out  DATA_W  last ALU result written back.
- done  out  1  one-cycle pulse per retired instruction.
- flag_z  out  1  zero flag of last legal result.
- flag_c  out  1  carry/borrow flag of last legal result.
- illegal  out  1  one-cycle pulse, coincident with done, for an illegal format.
- dbg_addr  in  RAW  debug register select.
- dbg_data  out  DATA_W  combinational read of registers[dbg_addr].

Behaviour:
- Instruction layout, MSB to LSB:
  - rx[RAW]
  - field[IMM_W]; ry = top RAW bits of field, imm = whole field
  - op[3]
  - fmt[2]
- fmt encoding:
  - 0: reg-reg, operand = registers[ry].
  - 1: immediate, operand = zero-extended imm.
  - 2, 3: illegal.
- op encoding, a = registers[rx], b = operand:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL: a << b[$clog2(DATA_W)-1:0].
  - 6 SHR: logical a >> b[$clog2(DATA_W)-1:0].
  - 7 MOV: b.
- Result widths and flags:
  - All results truncate modulo 2^DATA_W.
  - ADD: C = carry out of bit DATA_W-1.
  - SUB: C = borrow (a < b unsigned).
  - All other ops: C = 0.
  - Z = (result == 0).
- FSM states IDLE, EXEC, WB:
  - IDLE: instr_ready=1. On instr_valid at an edge, latch instr and go to EXEC. No valid means stay in IDLE.
  - EXEC: read a and b, compute result and flags into internal latches, go to WB.
  - WB: if legal, write registers[rx], update d_out, flag_z and flag_c. Always pulse done; pulse illegal if fmt >= 2. Go to IDLE.
- Latency and throughput:
  - Accept at edge T, internal latch at T+1, write-back, done and illegal at T+2.
  - done is high for the cycle after T+2; instr_ready is high again in that same cycle.
  - Maximum throughput is one instruction per 3 cycles.
- Instruction input: instr is sampled only at the accept edge; changes afterwards are ignored.
- Illegal instructions write no register and leave d_out and flags unchanged.
- rx == ry: the old value of rx is used as both operands.
- dbg_data shows the new value from the cycle after the write edge.
- reset_n low at any time, including mid-instruction, asynchronously forces:
  - state IDLE;
  - all registers, d_out, flags, done and illegal to 0;
  - the in-flight instruction is dropped with no done.
- instr_ready is 0 while reset_n is low and becomes 1 in the first cycle after release.

Decomposition:
- Package core_pkg holds:
  - op_t enum: ADD, SUB, AND, OR, XOR, SHL, SHR, MOV.
  - fmt_t enum: FMT_REG, FMT_IMM, FMT_ILL2, FMT_ILL3.
  - state_t enum: IDLE, EXEC, WB.
- One sub-module, param_alu: combinational, parametrised by DATA_W; inputs a, b, op; outputs y, c, z.
- Register file and FSM stay in param_core.

Test Plan (defaults, r* = 0 after reset):
- 0x20A1 (ADD r1, #5) -> done at T+2, d_out=0x0005, r1=5, Z=0, C=0, instr_ready low for exactly 2 cycles.
- Then 0x2400 (ADD r1, r1) -> r1=0x000A; dbg_addr=1 gives dbg_data=0x000A.
- Carry/zero sequence:
  - 0x5FFD (MOV r2, #0xFF) -> r2=0x00FF.
  - 0x4115 (SHL r2, #8) -> r2=0xFF00.
  - 0x5FE1 (ADD r2, #0xFF) -> r2=0xFFFF, C=0.
  - 0x4021 (ADD r2, #1) -> r2=0x0000, Z=1, C=1.
- 0x6025 (SUB r3, #1) with r3=0 -> r3=0xFFFF, C=1, Z=0.
- 0x20A2 (fmt=2) -> done=1 and illegal=1 same cycle; r1, d_out and flags unchanged.
- reset_n pulsed low one cycle after accepting 0x20A1 -> no done, r1=0, then instr_ready=1 in the first cycle after release; instr_valid held high continuously gives exactly one accept per 3 cycles.
